// File: rtl/core_pkg.sv
// Shared phase encodings and helpers for the core sequencer and phase-gated units.
package core_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WRITE  = 3'd4,
        HALT   = 3'd5
    } phase_t;

    // Control-transfer targets are word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/core_perf_cnt.sv
// Free-running cycle and retired-instruction counters for the core sequencer.
module core_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        halted,
    input  logic        retired,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (!halted)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (retired)
                instret_cnt <= instret_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction phase sequencer with PC update and self-loop halt.
// Optional performance counters are enabled by defining CORE_SEQ_PERF_EN.
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               is_mem,
    input  logic               mem_ready,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    output logic [STATE_W-1:0] state,
    output logic [31:0]        pc,
    output logic               reg_we,
    output logic               retired,
    output logic               halted
`ifdef CORE_SEQ_PERF_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instret_cnt
`endif
);

    phase_t      state_q;
    phase_t      state_n;
    logic [31:0] pc_q;
    logic [31:0] target_q;
    logic        is_mem_q;
    logic        taken_q;
    logic        halt_q;

    always_comb begin
        state_n = state_q;
        case (state_q)
            FETCH:   state_n = DECODE;
            DECODE:  state_n = EXEC;
            EXEC:    state_n = is_mem_q ? MEM : WRITE;
            MEM:     state_n = mem_ready ? WRITE : MEM;
            WRITE:   state_n = halt_q ? HALT : FETCH;
            HALT:    state_n = HALT;
            default: state_n = FETCH;
        endcase
    end

    // Outputs are registered from the next phase so they line up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            target_q <= '0;
            is_mem_q <= 1'b0;
            taken_q  <= 1'b0;
            halt_q   <= 1'b0;
            reg_we   <= 1'b0;
            retired  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state_q <= state_n;
            reg_we  <= (state_n == WRITE);
            retired <= (state_n == WRITE);
            halted  <= (state_n == HALT);
            case (state_q)
                DECODE: is_mem_q <= is_mem;
                EXEC: begin
                    taken_q  <= br_taken;
                    target_q <= word_align(br_target);
                    halt_q   <= br_taken && (word_align(br_target) == pc_q);
                end
                WRITE: begin
                    if (!halt_q)
                        pc_q <= taken_q ? target_q : pc_q + 32'd4;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;
    assign pc    = pc_q;

`ifdef CORE_SEQ_PERF_EN
    core_perf_cnt u_perf (
        .clk         (clk),
        .rst         (rst),
        .halted      (halted),
        .retired     (retired),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`endif

endmodule
